// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Data-memory controller between the processor memory stage and an inferred,
// byte-lane-writable on-chip RAM. It translates byte/half/word/dword stores
// into lane writes and loads into aligned, sign- or zero-extended results.
// Loads stall the processor for LOAD_LAT cycles. Misaligned accesses raise a
// trap instead of touching the RAM, and a separate write-only boot port can
// fill the RAM one full word at a time.
//
// Parameters
//   DW        data width, 32 or 64
//   DM_AW     word-address bits, RAM depth = 2**DM_AW words
//   LOAD_LAT  load stall cycles, 1..4
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   en            memory-stage access valid
//   op            {store, sign, size[1:0]}; size 11 byte, 01 half,
//                 00 word, 10 dword (word when DW = 32)
//   d_address     byte address; bit 31 selects the I/O region (no RAM write)
//   d_writedata   right-aligned store data
//   d_loadresult  extended load data, valid in RESP, 0 otherwise
//   stalled       processor must hold op/address/data while high
//   misaligned    misaligned-access trap
//   boot_dwe      boot write enable (full word)
//   boot_daddr    boot word address
//   boot_ddata    boot write data
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DW       = 32,
    parameter int DM_AW    = 8,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       op,
    input  logic [31:0]      d_address,
    input  logic [DW-1:0]    d_writedata,
    output logic [DW-1:0]    d_loadresult,
    output logic             stalled,
    output logic             misaligned,
    input  logic             boot_dwe,
    input  logic [DM_AW-1:0] boot_daddr,
    input  logic [DW-1:0]    boot_ddata
);

    localparam int NB = DW / 8;                 // byte lanes per word
    localparam int L  = (DW == 64) ? 3 : 2;     // lane-index bits

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b11;

    localparam logic [1:0]    CNT_INIT = 2'(LOAD_LAT - 1);
    localparam logic [DW-1:0] MASK8    = DW'(8'hFF);
    localparam logic [DW-1:0] MASK16   = DW'(16'hFFFF);
    localparam logic [DW-1:0] MASK32   = DW'(32'hFFFF_FFFF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // NOTE: the RAM array has no reset; its contents survive reset and are
    // only ever changed by CPU stores or the boot port.
    logic [DW-1:0] mem [2**DM_AW];

    // Request decode
    logic [1:0]       size;
    logic [L-1:0]     lane;
    logic [DM_AW-1:0] word_idx;
    logic             aligned;
    logic             is_idle;
    logic             load_req;
    logic             store_go;
    logic [NB-1:0]    cpu_be;      // bit i enables lane i (lane 0 = MSB byte)
    logic [DW-1:0]    cpu_wdata;
    logic [DW-1:0]    wr_base;
    logic [DW-1:0]    wr_word;

    // Load FSM state
    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [L-1:0]  lane_q, lane_d;
    logic [2:0]    op_q, op_d;       // {sign, effective size}
    logic [DW-1:0] rdata_q, rdata_d;

    // Load translation
    logic [DW-1:0] shifted;
    logic [DW-1:0] field;
    logic [DW-1:0] field_mask;
    logic          field_msb;
    logic [DW-1:0] ext;

    // Upper address bits between the word index and bit 31 do not matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^d_address;

    // -------------------------------------------------------------------------
    // Request decode, alignment and store lane formation
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        size      = op[1:0];
        lane      = d_address[L-1:0];
        word_idx  = d_address[DM_AW+L-1:L];
        aligned   = 1'b1;
        cpu_be    = '0;
        cpu_wdata = d_writedata;

        // A 32-bit datapath has no doubleword; it behaves as a word access.
        if (DW != 64 && size == SZ_DWORD) begin
            size = SZ_WORD;
        end

        unique case (size)
            SZ_BYTE: begin
                aligned   = 1'b1;
                cpu_be    = NB'(1) << lane;
                cpu_wdata = {NB{d_writedata[7:0]}};
            end
            SZ_HALF: begin
                aligned   = ~lane[0];
                cpu_be    = NB'(2'b11) << lane;
                cpu_wdata = {(NB/2){d_writedata[15:0]}};
            end
            SZ_WORD: begin
                aligned   = (lane[1:0] == 2'b00);
                cpu_be    = NB'(4'hF) << lane;
                cpu_wdata = {(NB/4){d_writedata[31:0]}};
            end
            default: begin
                aligned   = (lane == '0);
                cpu_be    = '1;
                cpu_wdata = d_writedata;
            end
        endcase
    end

    assign is_idle  = (state_q == IDLE);
    assign load_req = en & ~op[3] & aligned;
    // While a load is in flight op still describes that load, so stores are
    // only taken from IDLE.
    assign store_go = en & op[3] & aligned & ~d_address[31] & is_idle;

    assign stalled    = ~reset & ((is_idle & load_req) | (state_q == WAIT));
    assign misaligned = ~reset & en & is_idle & ~aligned;

    // -------------------------------------------------------------------------
    // RAM write path. A boot write to the same word on the same edge as a
    // store supplies the lanes the store does not enable.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_base = (boot_dwe && boot_daddr == word_idx) ? boot_ddata : mem[word_idx];
        wr_word = wr_base;
        for (int i = 0; i < NB; i++) begin
            if (cpu_be[i]) begin
                wr_word[DW-1-8*i -: 8] = cpu_wdata[DW-1-8*i -: 8];
            end
        end
    end

    // The store write is issued last so it wins on a shared word; wr_word
    // already carries the boot data for the lanes the store leaves alone.
    always_ff @(posedge clk) begin
        if (boot_dwe) begin
            mem[boot_daddr] <= boot_ddata;
        end
        if (store_go) begin
            mem[word_idx] <= wr_word;
        end
    end

    // -------------------------------------------------------------------------
    // Load FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        op_d    = op_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = (LOAD_LAT == 1) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                    lane_d  = lane;
                    op_d    = {op[2], size};
                    // Captured at the edge ending the request cycle, so a
                    // write on that same edge is not visible to this load.
                    rdata_d = mem[word_idx];
                end
            end
            WAIT: begin
                // Leave on the decrement that reaches zero so the result is
                // presented exactly LOAD_LAT cycles after the request.
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end
                if (cnt_q <= 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // en here still belongs to the completing load.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values that existed before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            op_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Load translation: bring the addressed lane(s) to the top of the word,
    // then right-align and extend.
    // -------------------------------------------------------------------------
    always_comb begin
        shifted    = rdata_q << {lane_q, 3'b000};
        field      = rdata_q;
        field_mask = '1;
        field_msb  = 1'b0;

        unique case (op_q[1:0])
            SZ_BYTE: begin
                field      = DW'(shifted[DW-1 -: 8]);
                field_mask = MASK8;
                field_msb  = shifted[DW-1];
            end
            SZ_HALF: begin
                field      = DW'(shifted[DW-1 -: 16]);
                field_mask = MASK16;
                field_msb  = shifted[DW-1];
            end
            SZ_WORD: begin
                // For DW = 32 the mask covers everything, so no extension.
                field      = DW'(shifted[DW-1 -: 32]);
                field_mask = MASK32;
                field_msb  = shifted[DW-1];
            end
            default: begin
                field      = rdata_q;
                field_mask = '1;
                field_msb  = 1'b0;
            end
        endcase

        ext = field | ((op_q[2] & field_msb) ? ~field_mask : '0);
    end

    assign d_loadresult = (~reset && state_q == RESP) ? ext : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Two instances: dut_a (DW=32, LOAD_LAT=1) and dut_b (DW=64, LOAD_LAT=3).
// The reference model is a plain byte array per instance: stores write N
// consecutive bytes big-endian, loads assemble N bytes and extend.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    localparam logic [3:0] OP_LB  = 4'b0111;
    localparam logic [3:0] OP_LBU = 4'b0011;
    localparam logic [3:0] OP_LH  = 4'b0101;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_LWU = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_SB  = 4'b1011;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1000;
    localparam logic [3:0] OP_SD  = 4'b1010;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        boot_we_a, boot_we_b;
    logic [7:0]  boot_addr;
    logic [63:0] boot_data;
    logic [31:0] res_a;
    logic        stl_a, mis_a;
    logic [63:0] res_b;
    logic        stl_b, mis_b;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DW(32), .DM_AW(8), .LOAD_LAT(LAT_A)) dut_a (
        .clk          (clk),
        .reset        (rst),
        .en           (en_a),
        .op           (op),
        .d_address    (addr),
        .d_writedata  (wdata[31:0]),
        .d_loadresult (res_a),
        .stalled      (stl_a),
        .misaligned   (mis_a),
        .boot_dwe     (boot_we_a),
        .boot_daddr   (boot_addr),
        .boot_ddata   (boot_data[31:0])
    );

    data_mem_ctrl #(.DW(64), .DM_AW(8), .LOAD_LAT(LAT_B)) dut_b (
        .clk          (clk),
        .reset        (rst),
        .en           (en_b),
        .op           (op),
        .d_address    (addr),
        .d_writedata  (wdata),
        .d_loadresult (res_b),
        .stalled      (stl_b),
        .misaligned   (mis_b),
        .boot_dwe     (boot_we_b),
        .boot_daddr   (boot_addr),
        .boot_ddata   (boot_data)
    );

    // ---------------------------------------------------------------- model
    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [2048];
    int n_vec  = 0;
    int n_fail = 0;

    function automatic int unsigned nbytes(input bit sel, input logic [1:0] sz);
        case (sz)
            2'b11:   return 1;
            2'b01:   return 2;
            2'b10:   return sel ? 8 : 4;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_misaligned(input bit sel, input logic [3:0] o, input logic [31:0] a);
        return (a % nbytes(sel, o[1:0])) != 0;
    endfunction

    function automatic logic [7:0] m_rd(input bit sel, input int unsigned ba);
        return sel ? mem_b[ba % 2048] : mem_a[ba % 1024];
    endfunction

    task automatic m_wr(input bit sel, input int unsigned ba, input logic [7:0] v);
        if (sel) mem_b[ba % 2048] = v;
        else     mem_a[ba % 1024] = v;
    endtask

    function automatic logic [63:0] m_load(input bit sel, input logic [3:0] o, input logic [31:0] a);
        int unsigned nb;
        int unsigned dwb;
        logic [63:0] v;
        nb  = nbytes(sel, o[1:0]);
        dwb = sel ? 64 : 32;
        v   = 64'h0;
        for (int k = 0; k < int'(nb); k++) v = (v << 8) | 64'(m_rd(sel, a + k));
        if (o[2] && nb * 8 < dwb && v[nb*8-1]) v = v | ~((64'd1 << (nb * 8)) - 64'd1);
        if (!sel) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic m_store(input bit sel, input logic [3:0] o, input logic [31:0] a, input logic [63:0] d);
        int unsigned nb;
        nb = nbytes(sel, o[1:0]);
        if (!m_misaligned(sel, o, a) && !a[31])
            for (int k = 0; k < int'(nb); k++) m_wr(sel, a + k, d[8*(int'(nb)-1-k) +: 8]);
    endtask

    task automatic m_boot(input bit sel, input logic [7:0] w, input logic [63:0] d);
        int nbw;
        nbw = sel ? 8 : 4;
        for (int k = 0; k < nbw; k++) m_wr(sel, int'(w) * nbw + k, d[8*(nbw-1-k) +: 8]);
    endtask

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] res_of(input bit sel);
        return sel ? res_b : {32'h0, res_a};
    endfunction
    function automatic logic stl_of(input bit sel);
        return sel ? stl_b : stl_a;
    endfunction
    function automatic logic mis_of(input bit sel);
        return sel ? mis_b : mis_a;
    endfunction

    // One access, entered and left at posedge+1. Optional boot write on the
    // request edge. Load data is predicted before the boot write is applied.
    task automatic do_op(input bit sel, input logic [3:0] o, input logic [31:0] a,
                         input logic [63:0] d, input bit bw, input logic [7:0] bwa,
                         input logic [63:0] bwd, input string tag,
                         output logic [63:0] got, output logic got_mis);
        bit          mis;
        bit          ld;
        int          lat;
        logic [63:0] exp;
        mis = m_misaligned(sel, o, a);
        ld  = !o[3];
        lat = sel ? LAT_B : LAT_A;
        exp = (ld && !mis) ? m_load(sel, o, a) : 64'h0;
        got = '0;
        op = o; addr = a; wdata = d; boot_addr = bwa; boot_data = bwd;
        if (sel) begin en_b = 1'b1; boot_we_b = bw; end
        else     begin en_a = 1'b1; boot_we_a = bw; end
        @(negedge clk);
        got_mis = mis_of(sel);
        check({tag, " misaligned"}, 64'(mis_of(sel)), 64'(mis));
        check({tag, " stalled req"}, 64'(stl_of(sel)), 64'(ld && !mis));
        check({tag, " result idle"}, res_of(sel), 64'h0);
        if (bw) m_boot(sel, bwa, bwd);
        if (!ld) m_store(sel, o, a, d);
        @(posedge clk); #1;
        boot_we_a = 1'b0; boot_we_b = 1'b0;
        if (ld && !mis) begin
            for (int c = 1; c < lat; c++) begin
                @(negedge clk);
                check({tag, " stalled wait"}, 64'(stl_of(sel)), 64'h1);
                @(posedge clk); #1;
            end
            @(negedge clk);
            check({tag, " stalled resp"}, 64'(stl_of(sel)), 64'h0);
            got = res_of(sel);
            check({tag, " load data"}, got, exp);
            @(posedge clk); #1;
        end
        en_a = 1'b0; en_b = 1'b0;
    endtask

    typedef struct {
        bit          sel;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [63:0] wdata;
        bit          exp_mis;
        bit          chk;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        logic [63:0] got;
        logic        gm;
        logic [63:0] bd;

        vt.push_back('{0, OP_SW,  32'h10, 64'h11223344, 0, 0, 64'h0,                 "a sw 10"});
        vt.push_back('{0, OP_LB,  32'h11, 64'h0,        0, 1, 64'h22,                "a lb 11"});
        vt.push_back('{0, OP_LH,  32'h12, 64'h0,        0, 1, 64'h3344,              "a lh 12"});
        vt.push_back('{0, OP_SB,  32'h13, 64'h80,       0, 0, 64'h0,                 "a sb 13"});
        vt.push_back('{0, OP_LB,  32'h13, 64'h0,        0, 1, 64'hFFFFFF80,          "a lb 13"});
        vt.push_back('{0, OP_LBU, 32'h13, 64'h0,        0, 1, 64'h80,                "a lbu 13"});
        vt.push_back('{0, OP_LW,  32'h10, 64'h0,        0, 1, 64'h11223380,          "a lw 10"});
        vt.push_back('{0, OP_LD,  32'h10, 64'h0,        0, 1, 64'h11223380,          "a ld-as-lw 10"});
        vt.push_back('{0, OP_LW,  32'h02, 64'h0,        1, 0, 64'h0,                 "a lw 02"});
        vt.push_back('{0, OP_SH,  32'h05, 64'hBEEF,     1, 0, 64'h0,                 "a sh 05"});
        vt.push_back('{0, OP_LW,  32'h04, 64'h0,        0, 0, 64'h0,                 "a lw 04"});
        vt.push_back('{1, OP_SD,  32'h08, 64'h0123456789ABCDEF, 0, 0, 64'h0,         "b sd 08"});
        vt.push_back('{1, OP_LW,  32'h0C, 64'h0,        0, 1, 64'hFFFFFFFF89ABCDEF,  "b lw 0c"});
        vt.push_back('{1, OP_LD,  32'h08, 64'h0,        0, 1, 64'h0123456789ABCDEF,  "b ld 08"});
        vt.push_back('{1, OP_LD,  32'h0C, 64'h0,        1, 0, 64'h0,                 "b ld 0c"});
        vt.push_back('{1, OP_LWU, 32'h08, 64'h0,        0, 1, 64'h01234567,          "b lwu 08"});
        vt.push_back('{1, OP_LH,  32'h0A, 64'h0,        0, 1, 64'h4567,              "b lh 0a"});
        vt.push_back('{1, OP_LB,  32'h0C, 64'h0,        0, 1, 64'hFFFFFFFFFFFFFF89,  "b lb 0c"});

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; op = '0; addr = '0; wdata = '0;
        boot_we_a = 1'b0; boot_we_b = 1'b0; boot_addr = '0; boot_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Outputs are forced low while reset is high, whatever en says.
        en_a = 1'b1; en_b = 1'b1; op = OP_LW; addr = 32'h10;
        @(negedge clk);
        check("rst stalled a", 64'(stl_a), 64'h0);
        check("rst stalled b", 64'(stl_b), 64'h0);
        @(posedge clk); #1;
        addr = 32'h2;
        @(negedge clk);
        check("rst misaligned a", 64'(mis_a), 64'h0);
        check("rst misaligned b", 64'(mis_b), 64'h0);
        @(posedge clk); #1;
        en_a = 1'b0; en_b = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post-rst stalled a", 64'(stl_a), 64'h0);
        check("post-rst result b", res_b, 64'h0);

        // Fill both RAMs through the boot port.
        for (int w = 0; w < 256; w++) begin
            bd = {$urandom, $urandom};
            boot_addr = 8'(w); boot_data = bd; boot_we_a = 1'b1; boot_we_b = 1'b1;
            m_boot(0, 8'(w), bd);
            m_boot(1, 8'(w), bd);
            @(posedge clk); #1;
        end
        boot_we_a = 1'b0; boot_we_b = 1'b0;

        // Directed table
        foreach (vt[i]) begin
            do_op(vt[i].sel, vt[i].op, vt[i].addr, vt[i].wdata, 1'b0, 8'h0, 64'h0,
                  vt[i].name, got, gm);
            check({vt[i].name, " table misaligned"}, 64'(gm), 64'(vt[i].exp_mis));
            if (vt[i].chk) check({vt[i].name, " table data"}, got, vt[i].exp);
        end

        // Reset in the middle of a LOAD_LAT=3 load drops it.
        op = OP_LD; addr = 32'h8; en_b = 1'b1;
        @(negedge clk);
        check("midrst stalled T", 64'(stl_b), 64'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst stalled T+1", 64'(stl_b), 64'h0);
        check("midrst result T+1", res_b, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; en_b = 1'b0;
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("midrst stalled T+%0d", c), 64'(stl_b), 64'h0);
            check($sformatf("midrst result T+%0d", c), res_b, 64'h0);
            @(posedge clk); #1;
        end
        do_op(1, OP_LD, 32'h8, 64'h0, 1'b0, 8'h0, 64'h0, "midrst reload", got, gm);
        check("midrst reload value", got, 64'h0123456789ABCDEF);

        // Boot write and CPU byte store to the same word on the same edge.
        do_op(0, OP_SB, 32'h14, 64'h00, 1'b1, 8'd5, 64'hDEADBEEF, "boot+sb", got, gm);
        do_op(0, OP_LW, 32'h14, 64'h0, 1'b0, 8'h0, 64'h0, "boot+sb lw", got, gm);
        check("boot+sb word5", got, 64'h00ADBEEF);
        do_op(0, OP_SW, 32'h80000014, 64'h12345678, 1'b0, 8'h0, 64'h0, "io sw", got, gm);
        do_op(0, OP_LW, 32'h14, 64'h0, 1'b0, 8'h0, 64'h0, "io lw", got, gm);
        check("io store no write", got, 64'h00ADBEEF);

        // Randomized accesses against the byte-array model.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 200; n++) begin
                logic [3:0]  ro;
                logic [31:0] ra;
                logic [63:0] rd;
                bit          rbw;
                logic [7:0]  rba;
                logic [63:0] rbd;
                ro  = 4'($urandom);
                ra  = $urandom;
                if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
                ra[31] = ($urandom_range(0, 7) == 0);
                rd  = {$urandom, $urandom};
                rbw = ($urandom_range(0, 3) == 0);
                rba = 8'($urandom);
                rbd = {$urandom, $urandom};
                do_op(s[0], ro, ra, rd, rbw, rba, rbd,
                      $sformatf("rand%0d.%0d op%h @%h", s, n, ro, ra), got, gm);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor to the single-cycle-stall data memory. It holds an inferred byte-enabled RAM, translates stores and loads for byte, half, word and (64-bit) doubleword accesses, and stalls the processor for a configurable number of cycles on loads. It adds misalignment trapping and a write-only boot port. It sits between the processor's memory stage and the on-chip data RAM.

## Interface
- DW, 32, data width; legal values 32 or 64.
- DM_AW, 8, word-address bits; depth is 2^DM_AW words.
- LOAD_LAT, 1, load stall cycles; legal range 1..4.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  memory-stage access valid.
- op  in  4  {store, sign, size1, size0}; size 11 = byte, 01 = half, 00 = word, 10 = dword (DW=64 only; treated as word when DW=32).
- d_address  in  32  byte address; bit 31 set = I/O region, which never writes the RAM.
- d_writedata  in  DW  store data, right-aligned.
- d_loadresult  out  DW  aligned, extended load data.
- stalled  out  1  processor must hold op, d_address and d_writedata while this is 1.
- misaligned  out  1  misaligned-access trap.
- boot_dwe  in  1  boot write enable.
- boot_daddr  in  DM_AW  boot word address.
- boot_ddata  in  DW  boot write data; always a full-word write.

## Operation
- Byte lanes are big-endian: lane 0 is bits [DW-1:DW-8]. The lane index is the low byte-address bits (2 bits for DW=32, 3 bits for DW=64). The RAM word index is d_address[DM_AW+L-1:L], with L = 2 or 3.
- Alignment requirements:
  - half: addr[0] = 0.
  - word: addr[1:0] = 0.
  - dword: addr[2:0] = 0.
  - misaligned = en & state IDLE & rule violated. A misaligned access writes nothing and never stalls.
- Store: when en, op[3] = 1, aligned and d_address[31] = 0, write the selected lanes at the clock edge.
  - Data is replicated or shifted into the addressed lanes; byte enables cover only those lanes.
  - Stores never stall.
- Load FSM, states IDLE, WAIT and RESP:
  - IDLE: an aligned load with en moves to WAIT. The FSM latches the low address bits and op, starts the RAM read, and loads cnt = LOAD_LAT-1. stalled = 1 in this request cycle.
  - WAIT: while cnt ≠ 0, stalled = 1 and cnt decrements. When cnt = 0, go to RESP.
  - For LOAD_LAT = 1 the FSM goes directly IDLE → RESP.
  - RESP: stalled = 0 and d_loadresult is valid. The next state is always IDLE, and en is ignored in RESP because it belongs to the completing load.
- Load translation:
  - byte and half: take the addressed lane(s) and fill the upper bits with op[2] & msb.
  - word (DW=64): extend likewise from bit 31.
  - word (DW=32) and dword: pass through.
- d_loadresult = 0 outside RESP.
- Boot port: writes the full word when boot_dwe = 1, in any state, independent of the CPU.
  - Same edge, same word as a CPU store: CPU-enabled lanes take CPU data and the rest take boot data.
- Read-during-write to the same word returns the old contents.

## Timing
- Load issued at cycle T: stalled = 1 for cycles T .. T+LOAD_LAT-1. At T+LOAD_LAT, stalled = 0 and d_loadresult is valid. Total occupancy is LOAD_LAT+1 cycles.
- The RAM word is sampled at the edge ending cycle T and held internally until RESP.
- Back-to-back loads: the next load is accepted in the IDLE cycle after RESP, with no bubble other than RESP itself.
- Reset, including mid-load:
  - state = IDLE, cnt = 0, latched address/op = 0.
  - stalled = 0, misaligned = 0, d_loadresult = 0 from the cycle reset is sampled.
  - RAM contents are not cleared. An in-flight load is dropped.
- stalled and misaligned are combinational from state, en, op and d_address; both are forced to 0 while reset = 1.

## Test plan
- DW=32, LOAD_LAT=1: SW 0x11223344 @0x10, then LB sign @0x11 → stalled high 1 cycle, then d_loadresult = 0x00000022; LH sign @0x12 → 0x00003344.
- DW=32: SB 0x80 @0x13, then LB sign @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; the other three bytes of the word are unchanged.
- LOAD_LAT=3: load at T → stalled = 1 for T, T+1, T+2; data valid at T+3; a second load at T+4 repeats the pattern; reset asserted at T+1 → stalled = 0 at T+2, state IDLE.
- Misaligned: LW @0x02 and SH @0x05 with en → misaligned = 1 that cycle, stalled = 0, and a following LW of the target word shows no change.
- DW=64: SD 0x0123456789ABCDEF @0x8, then LW sign @0xC → 0xFFFFFFFF89ABCDEF; LD @0x8 → full value; LD @0xC → misaligned = 1.
- Boot write 0xDEADBEEF to word 5 on the same edge as SB 0x00 @0x14 → word 5 reads 0x00ADBEEF. A store @0x80000014 leaves word 5 unchanged.
